mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The parameter DCACHE_PRIORITY SHALL default to 0; 0 selects round-robin, 1 selects fixed priority to dcache.
REQ-002 The module SHALL have a single clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 icache_addr  input  32  line address of the I-cache request.
REQ-006 icache_read  input  1  I-cache line read request, held until icache_resp.
REQ-007 icache_rdata  output  256  line data returned to the I-cache.
REQ-008 icache_resp  output  1  one-cycle I-cache completion pulse.
REQ-009 dcache_addr  input  32  line address of the D-cache request.
REQ-010 dcache_read  input  1  D-cache line read request, held until dcache_resp.
REQ-011 dcache_write  input  1  D-cache line writeback request, held until dcache_resp.
REQ-012 dcache_wdata  input  256  writeback line data.
REQ-013 dcache_rdata  output  256  line data returned to the D-cache.
REQ-014 dcache_resp  output  1  one-cycle D-cache completion pulse.
REQ-015 mem_addr  output  32  address to the burst adapter.
REQ-016 mem_read  output  1  line read to the burst adapter.
REQ-017 mem_write  output  1  line write to the burst adapter.
REQ-018 mem_wdata  output  256  write line to the burst adapter.
REQ-019 mem_rdata  input  256  read line from the burst adapter.
REQ-020 mem_resp  input  1  adapter completion pulse.

Function
REQ-021 The state machine SHALL have exactly three states: IDLE, GNT_I and GNT_D.
REQ-022 In IDLE, on a rising edge with only an I-cache request pending (icache_read=1), the block SHALL latch icache_addr and enter GNT_I.
REQ-023 In IDLE, on a rising edge with only a D-cache request pending (dcache_read|dcache_write), the block SHALL latch dcache_addr, dcache_wdata and the rw kind, then enter GNT_D.
REQ-024 When both clients request in IDLE with DCACHE_PRIORITY=0, the block SHALL grant the client not granted last; last_grant SHALL update on every grant.
REQ-025 When both clients request in IDLE with DCACHE_PRIORITY=1, the block SHALL always grant the D-cache.
REQ-026 If dcache_read and dcache_write are both 1, the block SHALL treat the request as a write.
REQ-027 mem_read, mem_write, mem_addr and mem_wdata SHALL be driven only from latched registers.
REQ-028 These mem_* outputs SHALL be 0 in IDLE.
REQ-029 In GNT_I, mem_read SHALL be 1, mem_write 0 and mem_wdata 0.
REQ-030 In GNT_D, exactly one of mem_read or mem_write SHALL be 1, according to the latched kind.
REQ-031 The mem_* outputs SHALL stay stable from grant until the cycle in which mem_resp=1.
REQ-032 Minimum latency SHALL be: request seen at edge N -> mem_read or mem_write asserted in cycle N+1.
REQ-033 In the cycle mem_resp=1 in GNT_x, x_resp SHALL be 1 and x_rdata=mem_rdata, combinationally in the same cycle.
REQ-034 In that same cycle the other client's resp and rdata SHALL be 0.
REQ-035 On that edge the state SHALL return to IDLE.
REQ-036 Because IDLE re-arbitrates one cycle after any mem_resp, back-to-back grants SHALL be separated by at least one IDLE cycle.
REQ-037 mem_resp while in IDLE SHALL be ignored, with no client resp and no state change.
REQ-038 If a client drops its request while granted, the block SHALL hold the transaction until mem_resp and still pulse that client's resp.
REQ-039 Outside the response cycle, icache_rdata and dcache_rdata SHALL be 0.
REQ-040 A waiting client SHALL be granted at or before the second arbitration after its request first appears in IDLE (no starvation under round-robin).

Reset
REQ-041 On rst=1 at an edge, state SHALL go to IDLE and the latched addr, wdata and rw SHALL be cleared to 0.
REQ-042 On rst=1 at an edge, last_grant SHALL be set to D so that the first tie goes to the I-cache.
REQ-043 After reset, all outputs SHALL be 0 in the following cycle.
REQ-044 Reset mid-transaction SHALL abandon the grant, drop mem_read and mem_write the next cycle, and suppress any client resp.

Verification
REQ-045 Single I read: icache_read=1, addr=0x0000_1000, mem_resp after 6 cycles with rdata=0xA5..A5 -> mem_read=1 from cycle N+1, mem_addr=0x1000, icache_resp=1 with rdata=0xA5..A5 for one cycle, dcache_resp=0.
REQ-046 D writeback: dcache_write=1, addr=0x0000_2040, wdata=0x0123..EF -> mem_write=1, mem_wdata=0x0123..EF held stable until mem_resp; dcache_resp pulses once.
REQ-047 Tie after reset, RR: both request at the same edge -> I granted first (mem_addr=I addr); after its resp, D granted on the next IDLE edge.
REQ-048 Tie with DCACHE_PRIORITY=1, I and D requesting continuously for 3 D transactions -> mem_addr always equals the D addr while D requests; I granted only when dcache_read=dcache_write=0.
REQ-049 Spurious and simultaneous events: mem_resp=1 in IDLE -> no resp; dcache_read=dcache_write=1 -> mem_write=1, mem_read=0.
REQ-050 Reset mid-burst: rst=1 two cycles after a GNT_D write -> next cycle mem_write=0, state IDLE, no dcache_resp; a following I request is granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-client cache-line arbiter: grants the I-cache or D-cache to a single
// burst adapter, holding the latched request until the adapter responds.
module mem_arbiter #(
  parameter int unsigned DCACHE_PRIORITY = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  icache_addr,
  input  logic         icache_read,
  output logic [255:0] icache_rdata,
  output logic         icache_resp,
  input  logic [31:0]  dcache_addr,
  input  logic         dcache_read,
  input  logic         dcache_write,
  input  logic [255:0] dcache_wdata,
  output logic [255:0] dcache_rdata,
  output logic         dcache_resp,
  output logic [31:0]  mem_addr,
  output logic         mem_read,
  output logic         mem_write,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t       state, state_next;
  logic [31:0]  addr_q, addr_next;
  logic [255:0] wdata_q, wdata_next;
  logic         rw_q, rw_next;            // 1 = writeback
  logic         last_grant, last_next;    // 1 = D-cache granted last
  logic         i_req, d_req, pick_d;

  always_comb begin
    i_req  = icache_read;
    d_req  = dcache_read | dcache_write;
    // D wins a tie under fixed priority, or under round-robin when I went last
    pick_d = d_req && (!i_req || (DCACHE_PRIORITY != 0) || !last_grant);

    state_next = state;
    addr_next  = addr_q;
    wdata_next = wdata_q;
    rw_next    = rw_q;
    last_next  = last_grant;

    case (state)
      IDLE: begin
        if (pick_d) begin
          state_next = GNT_D;
          addr_next  = dcache_addr;
          wdata_next = dcache_wdata;
          rw_next    = dcache_write;
          last_next  = 1'b1;
        end else if (i_req) begin
          state_next = GNT_I;
          addr_next  = icache_addr;
          wdata_next = '0;
          rw_next    = 1'b0;
          last_next  = 1'b0;
        end
      end
      GNT_I, GNT_D: begin
        if (mem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = '0;
    case (state)
      GNT_I: begin
        mem_addr = addr_q;
        mem_read = 1'b1;
      end
      GNT_D: begin
        mem_addr  = addr_q;
        mem_read  = !rw_q;
        mem_write = rw_q;
        mem_wdata = wdata_q;
      end
      default: ;
    endcase
  end

  // Responses are gated by rst so a reset in the completion cycle drops the pulse
  always_comb begin
    icache_resp  = (state == GNT_I) && mem_resp && !rst;
    dcache_resp  = (state == GNT_D) && mem_resp && !rst;
    icache_rdata = icache_resp ? mem_rdata : '0;
    dcache_rdata = dcache_resp ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rw_q       <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_next;
      addr_q     <= addr_next;
      wdata_q    <= wdata_next;
      rw_q       <= rw_next;
      last_grant <= last_next;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 round-robin, instance 1 D-cache priority,
// both checked every cycle against a transaction-level ownership model.
module tb_mem_arbiter;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst      [2];
  logic [31:0]  i_addr   [2];
  logic         i_read   [2];
  logic [255:0] i_rdata  [2];
  logic         i_resp   [2];
  logic [31:0]  d_addr   [2];
  logic         d_read   [2];
  logic         d_write  [2];
  logic [255:0] d_wdata  [2];
  logic [255:0] d_rdata  [2];
  logic         d_resp   [2];
  logic [31:0]  m_addr   [2];
  logic         m_read   [2];
  logic         m_write  [2];
  logic [255:0] m_wdata  [2];
  logic [255:0] m_rdata  [2];
  logic         m_resp   [2];

  mem_arbiter dut0 (
    .clk(clk), .rst(rst[0]),
    .icache_addr(i_addr[0]), .icache_read(i_read[0]),
    .icache_rdata(i_rdata[0]), .icache_resp(i_resp[0]),
    .dcache_addr(d_addr[0]), .dcache_read(d_read[0]), .dcache_write(d_write[0]),
    .dcache_wdata(d_wdata[0]), .dcache_rdata(d_rdata[0]), .dcache_resp(d_resp[0]),
    .mem_addr(m_addr[0]), .mem_read(m_read[0]), .mem_write(m_write[0]),
    .mem_wdata(m_wdata[0]), .mem_rdata(m_rdata[0]), .mem_resp(m_resp[0])
  );

  mem_arbiter #(.DCACHE_PRIORITY(1)) dut1 (
    .clk(clk), .rst(rst[1]),
    .icache_addr(i_addr[1]), .icache_read(i_read[1]),
    .icache_rdata(i_rdata[1]), .icache_resp(i_resp[1]),
    .dcache_addr(d_addr[1]), .dcache_read(d_read[1]), .dcache_write(d_write[1]),
    .dcache_wdata(d_wdata[1]), .dcache_rdata(d_rdata[1]), .dcache_resp(d_resp[1]),
    .mem_addr(m_addr[1]), .mem_read(m_read[1]), .mem_write(m_write[1]),
    .mem_wdata(m_wdata[1]), .mem_rdata(m_rdata[1]), .mem_resp(m_resp[1])
  );

  // Reference model: who owns the memory port (-1 none, 0 I-cache, 1 D-cache),
  // what was captured at grant time, and who won the previous grant.
  int           own      [2];
  int           last_who [2];
  logic [31:0]  cap_addr [2];
  logic [255:0] cap_data [2];
  logic         cap_wr   [2];
  logic         exp_iresp[2];
  logic         exp_dresp[2];

  int unsigned tests = 0;
  int unsigned fails = 0;

  localparam logic [255:0] PAT_A5   = {32{8'hA5}};
  localparam logic [255:0] PAT_0123 = {4{64'h0123_4567_89AB_CDEF}};

  task automatic check(input int q, input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL dut%0d %s: got %h expected %h", q, tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic idle_inputs(input int q);
    rst[q] = 1'b0; i_addr[q] = '0; i_read[q] = 1'b0;
    d_addr[q] = '0; d_read[q] = 1'b0; d_write[q] = 1'b0; d_wdata[q] = '0;
    m_rdata[q] = '0; m_resp[q] = 1'b0;
  endtask

  task automatic model_reset(input int q);
    own[q] = -1; last_who[q] = 1; cap_addr[q] = '0; cap_data[q] = '0; cap_wr[q] = 1'b0;
  endtask

  task automatic model_edge(input int q);
    bit wants_i, wants_d, d_wins;
    if (rst[q]) begin
      model_reset(q);
    end else if (own[q] == -1) begin
      wants_i = i_read[q];
      wants_d = d_read[q] || d_write[q];
      d_wins  = wants_d && (!wants_i || q == 1 || last_who[q] == 0);
      if (d_wins) begin
        own[q] = 1; last_who[q] = 1;
        cap_addr[q] = d_addr[q]; cap_data[q] = d_wdata[q]; cap_wr[q] = d_write[q];
      end else if (wants_i) begin
        own[q] = 0; last_who[q] = 0;
        cap_addr[q] = i_addr[q]; cap_data[q] = '0; cap_wr[q] = 1'b0;
      end
    end else if (m_resp[q]) begin
      own[q] = -1;
    end
  endtask

  task automatic check_dut(input int q);
    logic [31:0]  ea;
    logic [255:0] ew;
    logic         er, ewr;
    ea = '0; ew = '0; er = 1'b0; ewr = 1'b0;
    if (own[q] == 0) begin
      ea = cap_addr[q]; er = 1'b1;
    end else if (own[q] == 1) begin
      ea = cap_addr[q]; ew = cap_data[q]; er = !cap_wr[q]; ewr = cap_wr[q];
    end
    exp_iresp[q] = (own[q] == 0) && m_resp[q] && !rst[q];
    exp_dresp[q] = (own[q] == 1) && m_resp[q] && !rst[q];
    check(q, "mem_addr",     256'(m_addr[q]),  256'(ea));
    check(q, "mem_read",     256'(m_read[q]),  256'(er));
    check(q, "mem_write",    256'(m_write[q]), 256'(ewr));
    check(q, "mem_wdata",    m_wdata[q],       ew);
    check(q, "icache_resp",  256'(i_resp[q]),  256'(exp_iresp[q]));
    check(q, "dcache_resp",  256'(d_resp[q]),  256'(exp_dresp[q]));
    check(q, "icache_rdata", i_rdata[q],       exp_iresp[q] ? m_rdata[q] : '0);
    check(q, "dcache_rdata", d_rdata[q],       exp_dresp[q] ? m_rdata[q] : '0);
  endtask

  // One clock: inputs already driven; check mid-cycle, then advance the model.
  task automatic step();
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic wait_then_resp(input int q, input int n, input logic [255:0] data);
    repeat (n) step();
    m_resp[q] = 1'b1; m_rdata[q] = data;
    step();
    m_resp[q] = 1'b0; m_rdata[q] = '0;
  endtask

  task automatic rand_step(input int q);
    int k;
    if (exp_iresp[q] || $urandom_range(49) == 0) i_read[q] = 1'b0;
    else if (!i_read[q] && $urandom_range(2) == 0) begin
      i_read[q] = 1'b1; i_addr[q] = $urandom;
    end
    if (exp_dresp[q] || $urandom_range(49) == 0) begin
      d_read[q] = 1'b0; d_write[q] = 1'b0;
    end else if (!d_read[q] && !d_write[q]) begin
      k = int'($urandom_range(3));
      d_read[q]  = (k == 1) || (k == 3);
      d_write[q] = (k == 2) || (k == 3);
      d_addr[q]  = $urandom;
      d_wdata[q] = rand256();
    end
    m_resp[q]  = ($urandom_range(3) == 0);
    m_rdata[q] = rand256();
    rst[q]     = ($urandom_range(149) == 0);
    step();
  endtask

  initial begin
    for (int q = 0; q < 2; q++) begin
      idle_inputs(q);
      rst[q] = 1'b1;
      model_reset(q);
      exp_iresp[q] = 1'b0;
      exp_dresp[q] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    step();                                   // still in reset: all outputs 0
    rst[0] = 1'b0; rst[1] = 1'b0;
    step();

    // Single I-cache read
    i_read[0] = 1'b1; i_addr[0] = 32'h0000_1000;
    wait_then_resp(0, 6, PAT_A5);
    i_read[0] = 1'b0;
    step();

    // D-cache writeback
    d_write[0] = 1'b1; d_addr[0] = 32'h0000_2040; d_wdata[0] = PAT_0123;
    wait_then_resp(0, 5, rand256());
    d_write[0] = 1'b0; d_wdata[0] = '0;
    step();

    // Tie straight after reset: I first, then D on the next IDLE edge
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    i_read[0] = 1'b1; i_addr[0] = 32'h0000_3000;
    d_read[0] = 1'b1; d_addr[0] = 32'h0000_4000;
    wait_then_resp(0, 3, rand256());
    i_read[0] = 1'b0;
    wait_then_resp(0, 3, rand256());
    d_read[0] = 1'b0;
    step();

    // Spurious mem_resp in IDLE, then read+write together treated as write
    m_resp[0] = 1'b1; m_rdata[0] = rand256(); step(); step();
    m_resp[0] = 1'b0;
    d_read[0] = 1'b1; d_write[0] = 1'b1; d_addr[0] = 32'h0000_5000; d_wdata[0] = rand256();
    wait_then_resp(0, 2, rand256());
    d_read[0] = 1'b0; d_write[0] = 1'b0;
    step();

    // Reset two cycles into a writeback, with mem_resp landing in the reset cycle
    d_write[0] = 1'b1; d_addr[0] = 32'h0000_6000; d_wdata[0] = rand256();
    step(); step();
    rst[0] = 1'b1; m_resp[0] = 1'b1; step();
    rst[0] = 1'b0; m_resp[0] = 1'b0; d_write[0] = 1'b0;
    step();
    i_read[0] = 1'b1; i_addr[0] = 32'h0000_7000;
    wait_then_resp(0, 2, rand256());
    i_read[0] = 1'b0;
    step();

    // Fixed priority: D keeps requesting for three transactions while I waits
    i_read[1] = 1'b1; i_addr[1] = 32'h0000_8000;
    d_read[1] = 1'b1;
    for (int t = 0; t < 3; t++) begin
      d_addr[1] = 32'h0000_9000 + 32'(t * 64);
      wait_then_resp(1, 2, rand256());
    end
    d_read[1] = 1'b0;
    wait_then_resp(1, 2, rand256());
    i_read[1] = 1'b0;
    step();

    // Randomised traffic, round-robin then fixed priority
    for (int n = 0; n < 2000; n++) rand_step(0);
    idle_inputs(0);
    for (int n = 0; n < 2000; n++) rand_step(1);
    idle_inputs(1);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
